// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown for the traffic light phase timer.
// A prescaler sets the step rate; the count steps down in BCD, and expiry is reported as a one-cycle pulse.
module bcd_countdown_timer #(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       run,
  output logic [7:0] count,
  output logic       tick,
  output logic       zero,
  output logic       expired,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] presc_nxt;
  logic [7:0]       count_nxt;
  logic             tick_nxt;
  logic             expired_nxt;
  logic [7:0]       load_clean;

  // Out-of-range BCD digits are clamped to 9 so the display never shows a non-decimal glyph.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd0) begin
      r = {v[7:4], v[3:0] - 4'd1};
    end else begin
      r = {v[7:4] - 4'd1, 4'd9};
    end
    return r;
  endfunction

  assign load_clean = {clamp_digit(load_val[7:4]), clamp_digit(load_val[3:0])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= 8'h00;
      presc   <= '0;
      tick    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      presc   <= presc_nxt;
      tick    <= tick_nxt;
      expired <= expired_nxt;
    end
  end

  // Load overrides everything, including a prescaler wrap landing on the same cycle.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    presc_nxt   = presc;
    tick_nxt    = 1'b0;
    expired_nxt = 1'b0;

    if (load) begin
      count_nxt = load_clean;
      presc_nxt = '0;
      if (load_clean == 8'h00) begin
        state_nxt   = DONE;
        expired_nxt = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      case (state)
        RUN: begin
          if (count == 8'h00) begin
            state_nxt = DONE;
          end else if (run) begin
            if (presc == DIV_MAX) begin
              presc_nxt = '0;
              tick_nxt  = 1'b1;
              count_nxt = bcd_dec(count);
              if (count == 8'h01) begin
                state_nxt   = DONE;
                expired_nxt = 1'b1;
              end
            end else begin
              presc_nxt = presc + DIV_W'(1);
            end
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  assign zero = (count == 8'h00);
  assign busy = (state == RUN);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with a 4-cycle prescaler.
// Expected values are hand-computed from the countdown timing.
module tb_bcd_countdown_timer;

  localparam int CLK_DIV = 4;
  localparam int DIV_W   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       run;
  logic [7:0] count;
  logic       tick;
  logic       zero;
  logic       expired;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int n_ticks;
  int n_expired;

  bcd_countdown_timer #(
    .CLK_DIV(CLK_DIV),
    .DIV_W  (DIV_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .run     (run),
    .count   (count),
    .tick    (tick),
    .zero    (zero),
    .expired (expired),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic l, input logic [7:0] v, input logic r);
    load     = l;
    load_val = v;
    run      = r;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag, input int observed, input int expected);
    checks++;
    assert (observed == expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Reset asserted between clock edges
    #2 rst = 1'b1;
    #1;
    checkOutput("reset count", count, 8'h00);
    checkFlag("reset zero", zero, 1'b1);
    checkFlag("reset busy", busy, 1'b0);
    checkFlag("reset tick", tick, 1'b0);
    checkFlag("reset expired", expired, 1'b0);
    nextCycle();
    rst = 1'b0;
    nextCycle();

    $display("[TB] test 1: count down from 03");
    applyStimulus(1'b1, 8'h03, 1'b1);
    nextCycle();
    checkOutput("t1 load count", count, 8'h03);
    checkFlag("t1 load busy", busy, 1'b1);
    checkFlag("t1 load zero", zero, 1'b0);
    checkFlag("t1 load tick", tick, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      nextCycle();
      checkFlag($sformatf("t1 tick c%0d", i), tick, (i % 4) == 0);
      checkOutput($sformatf("t1 count c%0d", i), count, 8'(3 - i / 4));
      checkFlag($sformatf("t1 expired c%0d", i), expired, i == 12);
      checkFlag($sformatf("t1 busy c%0d", i), busy, i < 12);
    end
    checkFlag("t1 zero end", zero, 1'b1);
    nextCycle();
    checkFlag("t1 expired after", expired, 1'b0);
    checkFlag("t1 tick after", tick, 1'b0);
    checkOutput("t1 count holds", count, 8'h00);

    $display("[TB] test 2: borrow from 10");
    applyStimulus(1'b1, 8'h10, 1'b1);
    nextCycle();
    checkOutput("t2 load count", count, 8'h10);
    applyStimulus(1'b0, 8'h00, 1'b1);
    n_ticks   = 0;
    n_expired = 0;
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      if (tick) n_ticks++;
    end
    checkOutput("t2 borrow count", count, 8'h09);
    checkFlag("t2 borrow tick", tick, 1'b1);
    for (int i = 5; i <= 39; i++) begin
      nextCycle();
      if (tick) n_ticks++;
      if (expired) n_expired++;
    end
    checkCount("t2 early expired", n_expired, 0);
    checkCount("t2 ticks before end", n_ticks, 9);
    nextCycle();
    checkFlag("t2 expired", expired, 1'b1);
    checkOutput("t2 final count", count, 8'h00);
    checkFlag("t2 busy end", busy, 1'b0);

    $display("[TB] test 3: pause mid-count");
    applyStimulus(1'b1, 8'h05, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 6; i++) nextCycle();
    checkOutput("t3 before pause", count, 8'h04);
    applyStimulus(1'b0, 8'h00, 1'b0);
    n_ticks = 0;
    for (int i = 1; i <= 7; i++) begin
      nextCycle();
      if (tick) n_ticks++;
      checkOutput($sformatf("t3 frozen c%0d", i), count, 8'h04);
    end
    checkCount("t3 paused ticks", n_ticks, 0);
    checkFlag("t3 paused busy", busy, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    nextCycle();
    checkFlag("t3 resume tick1", tick, 1'b0);
    nextCycle();
    checkFlag("t3 resume tick2", tick, 1'b1);
    checkOutput("t3 resume count", count, 8'h03);
    n_expired = 0;
    for (int r = 3; r <= 13; r++) begin
      nextCycle();
      if (expired) n_expired++;
    end
    checkCount("t3 early expired", n_expired, 0);
    nextCycle();
    checkFlag("t3 expired at 20", expired, 1'b1);
    checkOutput("t3 final count", count, 8'h00);

    $display("[TB] test 4: load zero");
    applyStimulus(1'b1, 8'h00, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkFlag("t4 expired", expired, 1'b1);
    checkFlag("t4 busy", busy, 1'b0);
    checkFlag("t4 tick", tick, 1'b0);
    checkOutput("t4 count", count, 8'h00);
    nextCycle();
    checkFlag("t4 expired clears", expired, 1'b0);
    n_ticks = 0;
    for (int i = 1; i <= 10; i++) begin
      nextCycle();
      if (tick) n_ticks++;
    end
    checkCount("t4 no ticks", n_ticks, 0);
    checkOutput("t4 count holds", count, 8'h00);

    $display("[TB] test 5: clamp and reload on wrap");
    applyStimulus(1'b1, 8'hAF, 1'b1);
    nextCycle();
    checkOutput("t5 clamp AF", count, 8'h99);
    checkFlag("t5 busy", busy, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 3; i++) nextCycle();
    checkFlag("t5 pre-wrap tick", tick, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b1);
    nextCycle();
    checkOutput("t5 reload count", count, 8'h02);
    checkFlag("t5 reload tick", tick, 1'b0);
    checkFlag("t5 reload expired", expired, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    n_ticks = 0;
    for (int i = 1; i <= 3; i++) begin
      nextCycle();
      if (tick) n_ticks++;
    end
    checkCount("t5 restart no tick", n_ticks, 0);
    nextCycle();
    checkFlag("t5 first tick", tick, 1'b1);
    checkOutput("t5 first step", count, 8'h01);

    $display("[TB] test 6: async reset mid-count");
    applyStimulus(1'b1, 8'h4F, 1'b1);
    nextCycle();
    checkOutput("t6 clamp 4F", count, 8'h49);
    applyStimulus(1'b1, 8'h47, 1'b1);
    nextCycle();
    checkOutput("t6 load 47", count, 8'h47);
    applyStimulus(1'b0, 8'h00, 1'b1);
    nextCycle();
    nextCycle();
    #3 rst = 1'b1;
    #1;
    checkOutput("t6 rst count", count, 8'h00);
    checkFlag("t6 rst busy", busy, 1'b0);
    checkFlag("t6 rst tick", tick, 1'b0);
    checkFlag("t6 rst zero", zero, 1'b1);
    nextCycle();
    #2 rst = 1'b0;
    n_ticks = 0;
    for (int i = 1; i <= 8; i++) begin
      nextCycle();
      if (tick) n_ticks++;
    end
    checkCount("t6 no ticks after rst", n_ticks, 0);
    checkOutput("t6 count after rst", count, 8'h00);
    checkFlag("t6 busy after rst", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Two-digit BCD countdown register for the traffic light phase timer. Holds the remaining phase time (00-99 seconds) and steps it down once per prescaled tick using BCD decrement arithmetic (units 0 borrows from tens and becomes 9). Sits between the phase-sequencing FSM, which loads durations and consumes the expiry pulse, and the 7-segment display path, which consumes the count.

Parameters:
CLK_DIV, 50000000, clock cycles per count tick (1 s at 50 MHz); must be >= 2
DIV_W, 26, prescaler width; must satisfy 2^DIV_W >= CLK_DIV

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  one-cycle request to load load_val and (re)start the phase
load_val  input  8  BCD duration, [7:4] tens, [3:0] units
run  input  1  count enable; 0 pauses the prescaler and the count
count  output  8  current BCD count, registered
tick  output  1  one-cycle pulse on each prescaler wrap (a count step)
zero  output  1  level, high when count == 8'h00
expired  output  1  one-cycle pulse when the phase ends
busy  output  1  high in RUN state

Behaviour:
- Reset (async, rst=1): state IDLE, count=8'h00, prescaler=0, tick=0, expired=0; therefore zero=1, busy=0.
- States: IDLE, RUN, DONE. busy = (state==RUN). zero is combinational from count; all other outputs are registered.
- Load sanitising: any load_val nibble > 9 is clamped to 9 before it is stored (8'hA3 -> 8'h93, 8'h4F -> 8'h49).
- load has absolute priority in every state. On the load cycle: count <= sanitised value, prescaler <= 0, tick <= 0. Next state: RUN if value != 00; otherwise DONE with expired=1 in the following cycle.
- Prescaler: counts only when state==RUN and run=1. On reaching CLK_DIV-1 it wraps to 0 and tick=1 for one cycle, coincident with the count step. When run=0 the prescaler and count hold their values (pause, no reset).
- Count step (RUN, prescaler wrap, no load):
  - units != 0: units-1.
  - units == 0: tens-1, units=9.
  - count == 01 -> 00: expired=1 for that cycle; state becomes DONE.
  - The FSM never steps from 00, so 00 never wraps to 99.
- First tick occurs CLK_DIV run-enabled cycles after the load cycle. Loading N (N >= 1) gives expired exactly N*CLK_DIV run-enabled cycles after load.
- DONE: count holds 00 and the prescaler is idle. Stays in DONE until the next load.
- IDLE: count held, no counting; only load exits.
- Simultaneous load and wrap: load wins, no tick, no expired, no step.
- Load during DONE on the cycle expired would pulse: expired still pulses (it is registered from the previous step), and the new load takes effect.
- rst asserted mid-count: immediate return to reset values; the countdown is not resumed after rst deasserts.

Test Plan (CLK_DIV=4):
1. Reset, then load=1 with load_val=8'h03, run=1 -> tick every 4 cycles; count 03, 02, 01, 00; expired pulses once, coincident with the 01->00 step, 12 cycles after load; busy 1->0; zero=1 afterwards.
2. Load 8'h10, run=1 -> after the first tick count=8'h09 (borrow); after 10 ticks count=00 and expired fires.
3. Load 8'h05; drop run for 7 cycles mid-count -> count and prescaler frozen, no tick; resumes with the remaining prescaler phase; total enabled cycles to expired = 20.
4. Load 8'h00 -> state DONE, expired=1 one cycle later, count stays 00, no tick ever.
5. Load 8'hAF -> count=8'h99; re-assert load with 8'h02 on the same cycle as a prescaler wrap -> count=02, no tick, prescaler restarts at 0.
6. Assert rst asynchronously (between clock edges) while count=8'h47 -> count=00, busy=0, tick=0 immediately; no counting after rst deasserts until the next load.
